note_display_mux: RTL



---
 rtl/note_display_mux.sv | 84 ++++++++
 1 files changed

// File: rtl/note_display_mux.sv
// note_display_mux: scanned seven-segment note display; blinking cursor digit when SEG_BLINK_EN is defined
module note_display_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 12000,
  parameter int BLANK_CYCLES = 120,
  parameter int BLINK_DIV    = 3000000
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [4*NUM_DIGITS-1:0]                   notes,
  input  logic                                      load,
  input  logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] cursor,
  input  logic                                      cursor_valid,
  output logic [NUM_DIGITS-1:0]                     anode_n,
  output logic [6:0]                                seg_data,
  output logic                                      decimal
);
  localparam int CW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int NW = $clog2(SCAN_DIV);
  typedef enum logic {BLANK, DRIVE} state_t;
  state_t state, state_n;
  logic [NW-1:0] cnt, cnt_n;
  logic [CW-1:0] idx, idx_n;
  logic [NUM_DIGITS-1:0][3:0] shadow;
  logic slot_end, hide;
  function automatic logic [7:0] decode(input logic [3:0] c);
    case (c)
      4'd1:    decode = 8'h39;
      4'd2:    decode = 8'h5E;
      4'd3:    decode = 8'h79;
      4'd4:    decode = 8'h71;
      4'd5:    decode = 8'h6F;
      4'd6:    decode = 8'h77;
      4'd7:    decode = 8'h7C;
      4'd8:    decode = 8'hB9;
      default: decode = 8'h00;
    endcase
  endfunction
  always_comb begin
    slot_end = cnt == NW'(SCAN_DIV - 1);
    cnt_n    = slot_end ? '0 : cnt + 1'b1;
    idx_n    = !slot_end ? idx : (idx == CW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    state_n  = slot_end ? BLANK : (state == BLANK && cnt_n == NW'(BLANK_CYCLES)) ? DRIVE : state;
  end
`ifdef SEG_BLINK_EN
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] bcnt;
  logic hidden, bwrap;
  assign bwrap = bcnt == BW'(BLINK_DIV - 1);
  // hidden phase is looked ahead one edge so it lines up with the registered outputs
  assign hide = (hidden ^ bwrap) && cursor_valid && cursor == idx_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt   <= '0;
      hidden <= 1'b0;
    end else begin
      bcnt   <= bwrap ? '0 : bcnt + 1'b1;
      hidden <= hidden ^ bwrap;
    end
  end
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor, cursor_valid};
  assign hide = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      cnt      <= '0;
      idx      <= '0;
      state    <= BLANK;
      anode_n  <= '1;
      seg_data <= '0;
      decimal  <= 1'b0;
    end else begin
      shadow   <= load ? notes : shadow;
      cnt      <= cnt_n;
      idx      <= idx_n;
      state    <= state_n;
      anode_n  <= state_n == DRIVE ? ~(NUM_DIGITS'(1) << idx_n) : '1;
      {decimal, seg_data} <= (state_n == DRIVE && !hide) ? decode(shadow[idx_n]) : 8'h00;
    end
  end
endmodule
